// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline register with 2-entry skid, sync flush and saturating bubble counter.
// Latency 1 cycle; in_ready is a flop (low only while the skid entry is full), no comb path from out_ready.
module pipe_stage_reg #(
  parameter int                DATA_W   = 32,
  parameter int                CTRL_W   = 16,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0,
  parameter int                CNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              accept, release_w;
  logic              load_main, load_skid, main_from_skid;

  assign out_valid = (state != EMPTY);
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;
  assign occupancy = state;
  assign accept    = in_valid & in_ready;
  assign release_w = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Flush overrides every transition; a concurrent release simply completes downstream.
  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (accept && release_w) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_nxt = TWO;
            load_skid = 1'b1;
          end else if (release_w) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (release_w) begin
            state_nxt      = ONE;
            main_from_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Payload is left untouched by flush; only control is squashed to the NOP encoding.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_data <= '0;
      main_ctrl <= CTRL_RST;
      skid_data <= '0;
      skid_ctrl <= CTRL_RST;
    end else if (flush) begin
      main_ctrl <= CTRL_RST;
      skid_ctrl <= CTRL_RST;
    end else begin
      if (load_main) begin
        main_data <= in_data;
        main_ctrl <= in_ctrl;
      end else if (main_from_skid) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end
      if (load_skid) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready <= 1'b1;
    end else begin
      in_ready <= (state_nxt != TWO);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cnt <= '0;
    end else if (cnt_clr) begin
      bubble_cnt <= '0;
    end else if (!out_valid && out_ready && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed table, corner sequences, and random traffic against a queue model.
module tb_pipe_stage_reg;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [15:0] in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] out_ctrl;
  logic [1:0]  occupancy;
  logic        cnt_clr;
  logic [7:0]  bubble_cnt;

  int tests = 0;
  int fails = 0;

  pipe_stage_reg #(
    .DATA_W(32), .CTRL_W(16), .CTRL_RST(16'h0000), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .cnt_clr(cnt_clr), .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          iv;
    logic [31:0] id;
    logic [15:0] ic;
    bit          ordy;
    bit          ov;
    logic [31:0] od;
    logic [15:0] oc;
    logic [1:0]  occ;
    bit          ir;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [15:0] c;
  } item_t;

  vec_t  vecs[11];
  item_t mq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit iv, input logic [31:0] d, input logic [15:0] c, input bit ordy);
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_ctrl"}, out_ctrl, 0);
    chk({tag, "_occupancy"}, occupancy, 0);
  endtask

  initial begin
    bit          iv, ordy, fl, clr, acc, rel, ctrl_zero;
    int          pre, mb;
    logic [31:0] rd;
    logic [15:0] rc;

    //                iv id     ic      ordy ov od     oc      occ ir
    vecs[0]  = '{1, 32'h11, 16'h1, 1, 1, 32'h11, 16'h1, 2'd1, 1};
    vecs[1]  = '{1, 32'h22, 16'h2, 1, 1, 32'h22, 16'h2, 2'd1, 1};
    vecs[2]  = '{1, 32'h33, 16'h3, 1, 1, 32'h33, 16'h3, 2'd1, 1};
    vecs[3]  = '{1, 32'h44, 16'h4, 1, 1, 32'h44, 16'h4, 2'd1, 1};
    vecs[4]  = '{0, 32'h0,  16'h0, 1, 0, 32'h0,  16'h0, 2'd0, 1};
    vecs[5]  = '{1, 32'hA,  16'hA, 0, 1, 32'hA,  16'hA, 2'd1, 1};
    vecs[6]  = '{1, 32'hB,  16'hB, 0, 1, 32'hA,  16'hA, 2'd2, 0};
    vecs[7]  = '{1, 32'hC,  16'hC, 0, 1, 32'hA,  16'hA, 2'd2, 0};
    vecs[8]  = '{1, 32'hC,  16'hC, 1, 1, 32'hB,  16'hB, 2'd1, 1};
    vecs[9]  = '{1, 32'hC,  16'hC, 1, 1, 32'hC,  16'hC, 2'd1, 1};
    vecs[10] = '{0, 32'h0,  16'h0, 1, 0, 32'h0,  16'h0, 2'd0, 1};

    // Reset held while inputs toggle
    reset = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    drive(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(i[0], $urandom, 16'($urandom), ~i[0]);
      step();
      chk_reset_state("rst");
      chk("rst_out_data", out_data, 0);
      chk("rst_bubble", bubble_cnt, 0);
    end
    drive(0, 0, 0, 1);
    #3 reset = 1'b1;
    step();
    chk("first_bubble", bubble_cnt, 1);

    // Directed table: streaming, then backpressure with skid fill and drain
    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].id, vecs[i].ic, vecs[i].ordy);
      step();
      chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].ov);
      chk($sformatf("vec%0d_occupancy", i), occupancy, vecs[i].occ);
      chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].ir);
      if (vecs[i].ov) begin
        chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].od);
        chk($sformatf("vec%0d_out_ctrl", i), out_ctrl, vecs[i].oc);
      end
    end

    // Flush with the stage full and an input offered in the same cycle
    drive(1, 32'h1, 16'h00FF, 0); step();
    drive(1, 32'h2, 16'h00FF, 0); step();
    chk("flush_pre_occ", occupancy, 2);
    flush = 1'b1;
    drive(1, 32'hD, 16'h00FF, 0);
    step();
    flush = 1'b0;
    chk_reset_state("flush");
    chk("flush_data_held", out_data, 32'h1);
    drive(0, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("flush_no_ghost", out_valid, 0);
    end

    // Bubble counter saturation and clear priority
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    chk("clr_zero", bubble_cnt, 0);
    for (int i = 0; i < 255; i++) step();
    chk("bubble_255", bubble_cnt, 255);
    for (int i = 0; i < 45; i++) step();
    chk("bubble_sat", bubble_cnt, 255);
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    chk("clr_priority", bubble_cnt, 0);
    step();
    chk("after_clr", bubble_cnt, 1);

    // Asynchronous reset mid-transfer
    drive(1, 32'h7, 16'h7, 0); step();
    drive(1, 32'h8, 16'h8, 0); step();
    chk("arst_pre_occ", occupancy, 2);
    #2 reset = 1'b0;
    #1;
    chk_reset_state("arst");
    chk("arst_out_data", out_data, 0);
    step();
    drive(0, 0, 0, 1);
    #3 reset = 1'b1;
    drive(1, 32'h55, 16'h5, 1);
    step();
    chk("post_arst_valid", out_valid, 1);
    chk("post_arst_data", out_data, 32'h55);
    chk("post_arst_ctrl", out_ctrl, 16'h5);
    drive(0, 0, 0, 1);
    step();
    chk("post_arst_drain", out_valid, 0);

    // Random traffic against a FIFO-queue model
    reset = 1'b0; #2; reset = 1'b1;
    mq.delete(); mb = 0; ctrl_zero = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 39) == 0);
      clr  = ($urandom_range(0, 59) == 0);
      rd = $urandom; rc = 16'($urandom);
      drive(iv, rd, rc, ordy);
      flush = fl; cnt_clr = clr;
      pre = mq.size();
      acc = iv && (pre < 2);
      rel = (pre > 0) && ordy;
      if (clr) mb = 0;
      else if (pre == 0 && ordy && mb < 255) mb++;
      if (fl) begin
        mq.delete();
        ctrl_zero = 1'b1;
      end else begin
        if (rel) void'(mq.pop_front());
        if (acc) begin
          mq.push_back('{d: rd, c: rc});
          ctrl_zero = 1'b0;
        end
      end
      step();
      chk("rnd_out_valid", out_valid, mq.size() > 0);
      chk("rnd_occupancy", occupancy, mq.size());
      chk("rnd_in_ready", in_ready, mq.size() < 2);
      chk("rnd_bubble", bubble_cnt, mb);
      if (mq.size() > 0) begin
        chk("rnd_out_data", out_data, mq[0].d);
        chk("rnd_out_ctrl", out_ctrl, mq[0].c);
      end else if (ctrl_zero) begin
        chk("rnd_squash_ctrl", out_ctrl, 0);
      end
    end
    flush = 1'b0; cnt_clr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, elastic pipeline-stage register; successor to the fixed-field ID/EX latch.
- Used between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque data payload and a control bundle, with a valid/ready handshake, a 2-entry skid buffer, synchronous flush and a bubble counter.
- Flush squashes in-flight entries by forcing control to a safe value, so a flushed slot behaves as a NOP.

Parameters:
DATA_W, 32, width of payload (operands, immediates, register indices); not cleared on flush
CTRL_W, 16, width of control bundle (RegWrite, MemRead, MemWrite, ALUOp, ...)
CTRL_RST, 0, control value loaded on reset and flush (NOP encoding)
CNT_W, 8, width of bubble counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous squash of all held entries
in_valid  in  1  upstream has a word
in_ready  out  1  stage can accept a word; registered
in_data  in  DATA_W  upstream payload
in_ctrl  in  CTRL_W  upstream control
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts the word
out_data  out  DATA_W  payload of head entry
out_ctrl  out  CTRL_W  control of head entry
occupancy  out  2  entries held (0..2)
cnt_clr  in  1  synchronous clear of bubble_cnt
bubble_cnt  out  CNT_W  saturating count of bubble cycles

Behaviour:
- Handshake:
  - Accept happens when in_valid & in_ready.
  - Release happens when out_valid & out_ready.
  - in_valid is not required to stay stable while not accepted.
- Storage:
  - Main entry drives out_*.
  - Skid entry fills only when main is held.
  - in_ready = !skid_valid; it comes from a flop and has no combinational path from out_ready.
- States are EMPTY (occ 0), ONE (occ 1), TWO (occ 2):
  - EMPTY: accept -> ONE, main <= input.
  - ONE: accept & release -> ONE, main <= input. Accept only -> TWO, skid <= input. Release only -> EMPTY.
  - TWO: release -> ONE, main <= skid. No accept is possible (in_ready=0).
  - Other cases hold state.
- Ordering: strict FIFO. No word is dropped or duplicated except by flush.
- Latency and throughput: an accepted word appears on out_* the next cycle when the stage was EMPTY or released that cycle. Full throughput is 1 word/cycle with out_ready held high.
- Flush (synchronous, highest priority below reset):
  - Next state is EMPTY.
  - Both control registers load CTRL_RST.
  - Data registers hold.
  - in_ready is 1 the next cycle.
  - An input offered in the flush cycle is not stored; upstream must treat it as killed.
  - A release coinciding with flush completes normally.
- Reset (async assert, sync deassert by system) forces:
  - out_valid=0, occupancy=0, in_ready=1
  - out_ctrl=CTRL_RST, skid ctrl=CTRL_RST
  - out_data=0, skid data=0
  - bubble_cnt=0
  - Assertion mid-transfer discards all entries immediately, without waiting for a clock edge.
- Bubble counter:
  - Increments on each cycle with out_valid=0 & out_ready=1.
  - Saturates at 2^CNT_W-1; no wrap.
  - cnt_clr has priority: the counter is 0 next cycle even if a bubble occurs in the same cycle.
  - Flush does not clear it.
  - A cycle where flush empties the stage counts as a bubble only from the following cycle.
- out_data and out_ctrl are undefined-but-stable when out_valid=0, except after reset or flush, where the values above apply.

Test Plan:
(All scenarios use DATA_W=32, CTRL_W=16, CTRL_RST=0, CNT_W=8.)
1. Reset low with inputs toggling -> out_valid=0, in_ready=1, out_ctrl=0x0000, out_data=0, occupancy=0, bubble_cnt=0. After reset high, the first bubble cycle gives bubble_cnt=1.
2. out_ready=1, push data 0x11,0x22,0x33,0x44 with ctrl 0x0001..0x0004 on consecutive cycles -> each word on out_* exactly one cycle after acceptance, in order; in_ready stays 1; occupancy stays 1 while streaming.
3. out_ready=0, push A=0xA, B=0xB, then hold C=0xC valid -> occupancy=2 and in_ready=0 the cycle after B; C not accepted. Raise out_ready -> outputs A,B,C on successive cycles, no loss or duplicate, in_ready returns to 1.
4. Occupancy=2 (ctrl 0x00FF each), assert flush with in_valid=1, data 0xD -> next cycle: out_valid=0, out_ctrl=0x0000, occupancy=0, in_ready=1; 0xD never appears on the output.
5. out_ready=1, in_valid=0 for 300 cycles -> bubble_cnt reaches 255 and holds. Pulse cnt_clr during a bubble cycle -> bubble_cnt=0 the next cycle, 1 the cycle after.
6. Occupancy=2, drive reset low between clock edges -> out_valid and occupancy drop to 0 and out_ctrl to 0x0000 immediately, without a clock edge. After release, a new push of 0x55 emerges cleanly.
